// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_slave_regfile                                            |
// | Description : I2C target with a byte register file. SCL/SDA are            |
// |               synchronised and glitch-filtered on clk. START, repeated      |
// |               START and STOP are detected, the 7-bit address is decoded,    |
// |               and pointer-addressed burst writes and reads auto-increment.  |
// |               A host port reads and writes the same registers locally.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   system clock, at least 16x the SCL rate                  |
// |   reset      in   asynchronous, active-high reset                          |
// |   scl_i      in   raw SCL from pad                                         |
// |   sda_i      in   raw SDA from pad                                         |
// |   sda_oe     out  1 = pull SDA low, 0 = release                            |
// |   host_we    in   host write strobe                                        |
// |   host_addr  in   host register index (read and write)                     |
// |   host_wdata in   host write data                                          |
// |   host_rdata out  regs[host_addr], combinational                           |
// |   wr_valid   out  one-clk pulse per I2C data byte written                  |
// |   wr_addr    out  index of that byte, valid with wr_valid                  |
// |   busy       out  high from address match until STOP or mismatch           |
// |   state      out  FSM state for debug                                      |
// +----------------------------------------------------------------------------+
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         DEPTH      = 16,
  parameter int         FILTER     = 3,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic [1:0] w_rise;
  logic [1:0] w_fall;

  assign w_raw = {sda_i, scl_i};

  // Two-flop synchroniser followed by a run-length filter: a new level is
  // accepted only after FILTER consecutive samples disagree with the current
  // one. The edge pulses are issued in the same clk the filtered level moves.
  for (genvar k = 0; k < 2; k++) begin : g_filt
    logic       r_meta;
    logic       r_sync;
    logic       r_lvl;
    logic       r_rise;
    logic       r_fall;
    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_meta <= 1'b1;
        r_sync <= 1'b1;
        r_lvl  <= 1'b1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_meta <= w_raw[k];
        r_sync <= r_meta;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (r_sync == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == 4'(FILTER - 1)) begin
          r_lvl  <= r_sync;
          r_rise <= r_sync;
          r_fall <= ~r_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_lvl[k]  = r_lvl;
    assign w_rise[k] = r_rise;
    assign w_fall[k] = r_fall;
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = w_rise[0];
  assign w_scl_fall = w_fall[0];
  assign w_start    = w_fall[1] & w_lvl[0];
  assign w_stop     = w_rise[1] & w_lvl[0];

  state_t           r_state;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [PTR_W-1:0] r_ptr;
  logic             r_rw;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_wr_valid;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_regs [DEPTH];

  logic [7:0] w_shift_in;
  logic [7:0] w_rd_byte;
  logic       w_i2c_we;

  assign w_shift_in = {r_shift[6:0], w_lvl[1]};
  assign w_rd_byte  = r_regs[r_ptr];
  // The data byte commits on the SCL rise that samples its eighth bit.
  assign w_i2c_we   = (r_state == S_WDATA) && w_scl_rise && !w_start && !w_stop
                      && (r_bit_cnt == 4'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_i2c_we) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_ptr      <= r_ptr + PTR_W'(1);
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == SLAVE_ADDR) begin
                  r_state  <= S_ADDR_ACK;
                  r_sda_oe <= 1'b1;
                  r_busy   <= 1'b1;
                  r_rw     <= r_shift[0];
                end else begin
                  r_state  <= S_IGNORE;
                  r_sda_oe <= 1'b0;
                  r_busy   <= 1'b0;
                end
              end else if (r_state == S_PTR) begin
                r_ptr    <= r_shift[PTR_W-1:0];
                r_state  <= S_PTR_ACK;
                r_sda_oe <= 1'b1;
              end else begin
                r_state  <= S_WDATA_ACK;
                r_sda_oe <= 1'b1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                // Read: first data bit goes out on the same fall that ends the ACK.
                r_state   <= S_RDATA;
                r_shift   <= w_rd_byte;
                r_sda_oe  <= ~w_rd_byte[7];
                r_bit_cnt <= 4'd1;
              end else begin
                r_state   <= S_PTR;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_state   <= S_WDATA;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          S_RDATA: begin
            // r_bit_cnt counts bits already driven; 0 means the byte is not loaded yet.
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd0) begin
                r_shift   <= w_rd_byte;
                r_sda_oe  <= ~w_rd_byte[7];
                r_bit_cnt <= 4'd1;
              end else if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_ptr    <= r_ptr + PTR_W'(1);
                r_state  <= S_RDATA_ACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!w_lvl[1]) begin
                r_state   <= S_RDATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The I2C write is issued after the host write so it wins on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_i2c_we) begin
        r_regs[r_ptr] <= w_shift_in;
      end
    end
  end

  assign host_rdata = r_regs[host_addr];
  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign state      = r_state;

endmodule
`default_nettype wire
